// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: memory geometry and the program loader states.
package sap1_pkg;

   localparam int SAP1_ADDR_W = 4;
   localparam int SAP1_DATA_W = 8;
   localparam int SAP1_DEPTH  = 1 << SAP1_ADDR_W;

   typedef enum logic [2:0] {
      LD_IDLE,
      LD_HDR,
      LD_DATA,
      LD_CSUM,
      LD_COMMIT,
      LD_RUN,
      LD_ERR
   } ld_state_e;

   function automatic logic ld_in_frame(input ld_state_e s);
      return s inside {LD_HDR, LD_DATA, LD_CSUM, LD_COMMIT};
   endfunction

endpackage

// File: rtl/sap1_frame_buf.sv
// 16x8 staging buffer for one loader frame: plain write port, registered read.
module sap1_frame_buf
   import sap1_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic                   we,
   input  logic [SAP1_ADDR_W-1:0] waddr,
   input  logic [SAP1_DATA_W-1:0] wdata,
   input  logic                   re,
   input  logic [SAP1_ADDR_W-1:0] raddr,
   output logic [SAP1_DATA_W-1:0] rdata
);

   logic [SAP1_DATA_W-1:0] mem [SAP1_DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sap1_ram_loader.sv
// Host-link program loader: buffers and checksums a frame, commits it to
// the SAP-1 program RAM, and holds the CPU in reset until it is done.
module sap1_ram_loader
   import sap1_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic                   clk_i,
   input  logic                   rstn_i,
   input  logic [SAP1_DATA_W-1:0] in_data_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   output logic                   ram_we_o,
   output logic [SAP1_ADDR_W-1:0] ram_addr_o,
   output logic [SAP1_DATA_W-1:0] ram_wdata_o,
   output logic                   cpu_rstn_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o
);

   ld_state_e state, state_nx;

   logic [SAP1_ADDR_W-1:0] start_q;
   logic [SAP1_ADDR_W-1:0] cnt_q;
   logic [SAP1_ADDR_W-1:0] idx_q;
   logic [SAP1_DATA_W-1:0] sum_q;
   logic [SAP1_DATA_W-1:0] sum_nx;
   logic                   last_q;
   logic                   acc;
   logic                   is_sync;
   logic                   at_last;
   logic                   buf_we;
   logic                   buf_re;

   assign acc     = in_valid_i && in_ready_o;
   assign is_sync = (in_data_i == SYNC_BYTE);
   assign sum_nx  = sum_q + in_data_i;
   assign at_last = (idx_q == cnt_q);
   assign buf_we  = acc && (state == LD_DATA);
   assign buf_re  = (state == LD_COMMIT);

   sap1_frame_buf u_buf (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .we     (buf_we),
      .waddr  (idx_q),
      .wdata  (in_data_i),
      .re     (buf_re),
      .raddr  (idx_q),
      .rdata  (ram_wdata_o)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state <= LD_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         LD_IDLE, LD_RUN, LD_ERR: begin
            if (acc && is_sync) state_nx = LD_HDR;
         end
         LD_HDR: begin
            if (acc) state_nx = LD_DATA;
         end
         LD_DATA: begin
            if (acc && at_last) state_nx = LD_CSUM;
         end
         LD_CSUM: begin
            if (acc) begin
               state_nx = (sum_nx == '0) ? LD_COMMIT : LD_ERR;
            end
         end
         LD_COMMIT: begin
            if (at_last) state_nx = LD_RUN;
         end
         default: state_nx = LD_IDLE;
      endcase
   end

   // idx_q indexes the buffer while filling and again while committing
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         start_q <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         sum_q   <= '0;
      end else begin
         unique case (state)
            LD_HDR: begin
               if (acc) begin
                  start_q <= in_data_i[7:4];
                  cnt_q   <= in_data_i[3:0];
                  sum_q   <= in_data_i;
                  idx_q   <= '0;
               end
            end
            LD_DATA: begin
               if (acc) begin
                  sum_q <= sum_nx;
                  idx_q <= idx_q + 4'd1;
               end
            end
            LD_CSUM: begin
               if (acc) idx_q <= '0;
            end
            LD_COMMIT: begin
               idx_q <= idx_q + 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         in_ready_o <= 1'b1;
         ram_we_o   <= 1'b0;
         ram_addr_o <= '0;
         cpu_rstn_o <= 1'b0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         err_o      <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         in_ready_o <= (state_nx != LD_COMMIT);
         ram_we_o   <= (state == LD_COMMIT);
         if (state == LD_COMMIT) begin
            ram_addr_o <= start_q + idx_q;
         end
         last_q     <= (state == LD_COMMIT) && at_last;
         done_o     <= last_q;
         cpu_rstn_o <= (state == LD_RUN);
         busy_o     <= ld_in_frame(state);
         err_o      <= (state == LD_ERR) && !(acc && is_sync);
      end
   end

endmodule

// File: tb/tb_sap1_ram_loader.sv
// Bench for sap1_ram_loader: frame-level model with timestamped expectations.
module tb_sap1_ram_loader;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam longint INF = 64'd1 << 40;

   logic       clk_i = 1'b0;
   logic       rstn_i = 1'b0;
   logic [7:0] in_data_i = 8'h00;
   logic       in_valid_i = 1'b0;
   logic       in_ready_o;
   logic       ram_we_o;
   logic [3:0] ram_addr_o;
   logic [7:0] ram_wdata_o;
   logic       cpu_rstn_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;

   sap1_ram_loader #(.SYNC_BYTE(SYNC)) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .in_data_i   (in_data_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .ram_we_o    (ram_we_o),
      .ram_addr_o  (ram_addr_o),
      .ram_wdata_o (ram_wdata_o),
      .cpu_rstn_o  (cpu_rstn_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [7:0] act,
                        input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp,
                  $time);
      end
   endtask

   // Frame-level model: each accepted byte updates event timestamps
   longint cyc = 0;
   int     mode = 0;
   int     fstart, fn, fsum;
   logic [7:0] fq[$];
   longint cT = -1000;
   int     cn = 1;
   int     cstart = 0;
   logic [7:0] cdat [16];
   logic [7:0] exp_ram [16];
   longint run_start = INF, stop_at = INF;
   longint busy_start = INF, busy_end = INF;
   longint err_set = INF, err_clr = INF;

   function automatic logic exp_ready(input longint e);
      return !(e >= cT && e <= cT + cn - 1);
   endfunction

   function automatic logic exp_we(input longint e);
      return e >= cT + 1 && e <= cT + cn;
   endfunction

   task automatic accept(input logic [7:0] b, input longint e);
      case (mode)
         0: if (b == SYNC) begin
            mode = 1;
            busy_start = e + 1;
            busy_end = INF;
            err_clr = e;
            if (e >= run_start && stop_at == INF) stop_at = e + 1;
         end
         1: begin
            fstart = int'(b[7:4]);
            fn = int'(b[3:0]) + 1;
            fsum = int'(b);
            fq.delete();
            mode = 2;
         end
         2: begin
            fq.push_back(b);
            fsum += int'(b);
            if (fq.size() == fn) mode = 3;
         end
         default: begin
            mode = 0;
            if (((fsum + int'(b)) % 256) == 0) begin
               cT = e;
               cn = fn;
               cstart = fstart;
               for (int i = 0; i < fn; i++) begin
                  cdat[i] = fq[i];
                  exp_ram[(fstart + i) % 16] = fq[i];
               end
               busy_end = e + fn + 1;
               run_start = e + fn + 1;
               stop_at = INF;
            end else begin
               err_set = e + 1;
               err_clr = INF;
               busy_end = e + 1;
            end
         end
      endcase
   endtask

   always @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mode = 0;
         cT = -1000;
         cn = 1;
         run_start = INF;
         stop_at = INF;
         busy_start = INF;
         busy_end = INF;
         err_set = INF;
         err_clr = INF;
      end else begin
         cyc++;
         if (in_valid_i && exp_ready(cyc - 1)) accept(in_data_i, cyc);
      end
   end

   logic [7:0] shadow [16];
   int we_cnt = 0, done_cnt = 0, low_cnt = 0;

   // Per-cycle compare against the model, plus a shadow copy of the RAM
   always @(negedge clk_i) begin
      if (!rstn_i) begin
         check("rst_ready", {7'd0, in_ready_o}, 8'd1);
         check("rst_we", {7'd0, ram_we_o}, 8'd0);
         check("rst_addr", {4'd0, ram_addr_o}, 8'd0);
         check("rst_wdata", ram_wdata_o, 8'd0);
         check("rst_cpu", {7'd0, cpu_rstn_o}, 8'd0);
         check("rst_busy", {7'd0, busy_o}, 8'd0);
         check("rst_done", {7'd0, done_o}, 8'd0);
         check("rst_err", {7'd0, err_o}, 8'd0);
      end else begin
         check("ready", {7'd0, in_ready_o}, {7'd0, exp_ready(cyc)});
         check("we", {7'd0, ram_we_o}, {7'd0, exp_we(cyc)});
         if (exp_we(cyc)) begin
            check("addr", {4'd0, ram_addr_o},
                  8'((cstart + int'(cyc - cT - 1)) % 16));
            check("wdata", ram_wdata_o, cdat[int'(cyc - cT - 1)]);
         end
         check("cpu", {7'd0, cpu_rstn_o},
               {7'd0, cyc >= run_start && cyc < stop_at});
         check("busy", {7'd0, busy_o},
               {7'd0, cyc >= busy_start && cyc < busy_end});
         check("done", {7'd0, done_o}, {7'd0, cyc == cT + cn + 1});
         check("err", {7'd0, err_o},
               {7'd0, cyc >= err_set && cyc < err_clr});
         if (ram_we_o) begin
            shadow[ram_addr_o] = ram_wdata_o;
            we_cnt++;
         end
         if (done_o) done_cnt++;
         if (!in_ready_o) low_cnt++;
      end
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      in_data_i = b;
      in_valid_i = 1'b1;
      while (!in_ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 200) begin
         failures++;
         $display("FAIL send_timeout actual=stalled required=ready");
      end
      @(negedge clk_i);
      in_valid_i = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] f[$]);
      foreach (f[i]) send(f[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   int w0, l0;

   initial begin
      for (int i = 0; i < 16; i++) begin
         shadow[i] = 8'h00;
         exp_ram[i] = 8'h00;
      end
      in_valid_i = 1'b1;
      in_data_i = 8'h5C;
      idle(4);
      in_valid_i = 1'b0;
      rstn_i = 1'b1;
      idle(2);

      // junk before SYNC, then basic load
      send(8'h00);
      send(8'h5A);
      send_frame('{8'hA5, 8'h02, 8'h0E, 8'h2F, 8'hF0, 8'hD1});
      idle(6);
      check("basic_ram0", shadow[0], 8'h0E);
      check("basic_ram1", shadow[1], 8'h2F);
      check("basic_ram2", shadow[2], 8'hF0);
      check("basic_done", 8'(done_cnt), 8'd1);
      check("basic_cpu", {7'd0, cpu_rstn_o}, 8'd1);
      check("basic_err", {7'd0, err_o}, 8'd0);

      // wrap 15 -> 0
      send_frame('{8'hA5, 8'hF1, 8'h11, 8'h22, 8'hDC});
      idle(6);
      check("wrap_ram15", shadow[15], 8'h11);
      check("wrap_ram0", shadow[0], 8'h22);
      check("wrap_ram1", shadow[1], 8'h2F);
      check("wrap_cpu", {7'd0, cpu_rstn_o}, 8'd1);

      // bad checksum, then a good frame
      w0 = we_cnt;
      send_frame('{8'hA5, 8'h02, 8'h0E, 8'h2F, 8'hF0, 8'hD0});
      idle(6);
      check("bad_err", {7'd0, err_o}, 8'd1);
      check("bad_cpu", {7'd0, cpu_rstn_o}, 8'd0);
      check("bad_nowr", 8'(we_cnt - w0), 8'd0);
      check("bad_ram0", shadow[0], 8'h22);
      send(8'hA5);
      check("resync_err", {7'd0, err_o}, 8'd0);
      send_frame('{8'h02, 8'h0E, 8'h2F, 8'hF0, 8'hD1});
      idle(6);
      check("reload_ram0", shadow[0], 8'h0E);
      check("reload_done", 8'(done_cnt), 8'd3);

      // full reload with a byte held during commit
      w0 = we_cnt;
      l0 = low_cnt;
      send(8'hA5);
      check("bp_cpu_s", {7'd0, cpu_rstn_o}, 8'd1);
      send(8'h0F);
      check("bp_cpu_s1", {7'd0, cpu_rstn_o}, 8'd0);
      check("bp_busy", {7'd0, busy_o}, 8'd1);
      for (int i = 0; i < 16; i++) send(8'(i));
      send(8'h79);
      send(8'h3C);
      idle(4);
      check("bp_low16", 8'(low_cnt - l0), 8'd16);
      check("bp_wr16", 8'(we_cnt - w0), 8'd16);
      for (int i = 0; i < 16; i++) check("bp_ram", shadow[i], 8'(i));
      check("bp_cpu", {7'd0, cpu_rstn_o}, 8'd1);

      // reset in the middle of a frame
      w0 = we_cnt;
      send_frame('{8'hA5, 8'h03, 8'h11, 8'h22});
      #2 rstn_i = 1'b0;
      #1;
      check("mid_busy", {7'd0, busy_o}, 8'd0);
      check("mid_ready", {7'd0, in_ready_o}, 8'd1);
      check("mid_cpu", {7'd0, cpu_rstn_o}, 8'd0);
      idle(3);
      rstn_i = 1'b1;
      send_frame('{8'h33, 8'h44});
      idle(4);
      check("mid_nowr", 8'(we_cnt - w0), 8'd0);
      send_frame('{8'hA5, 8'h31, 8'hAA, 8'hBB, 8'h6A});
      idle(5);
      check("post_ram3", shadow[3], 8'hAA);
      check("post_ram4", shadow[4], 8'hBB);
      check("post_cpu", {7'd0, cpu_rstn_o}, 8'd1);

      for (int i = 0; i < 16; i++) check("final_ram", shadow[i], exp_ram[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
